// File: rtl/lsu_riscv_if.sv
// Word-addressed data-memory port between the LSU (master) and data memory (slave).
interface lsu_riscv_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_rvalid;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_rdata, data_rvalid
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_rdata, data_rvalid
  );
endinterface

// File: rtl/lsu_riscv.sv
// RV32 load/store unit: IDLE/BUSY/DONE handshake to a word-addressed memory,
// byte-lane steering for stores and sign/zero extension for loads.
module lsu_riscv (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  lsu_riscv_if.master mem
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [29:0] word;
    logic [31:0] wdata;
  } mem_req_t;

  logic [1:0]      state;
  mem_req_t        req_q;
  logic [2:0]      size_q;
  logic [1:0]      off_q;
  logic [1:0]      off;
  logic [1:0]      sz;
  logic            illegal;
  logic [3:0]      be_nxt;
  logic [3:0][7:0] wdata_nxt;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_ext;

  assign off = lsu_addr_i[1:0];
  assign sz  = lsu_size_i[1:0];
  assign illegal = (lsu_size_i inside {3'd3, 3'd6, 3'd7})
                 || (sz == 2'd1 && lsu_addr_i[0])
                 || (sz == 2'd2 && |off);

  // Per byte lane: enable and the replicated store byte it carries.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign be_nxt[i]    = (sz == 2'd0) ? (off == LANE)
                        : (sz == 2'd1) ? (off[1] == LANE[1]) : 1'b1;
    assign wdata_nxt[i] = (sz == 2'd0) ? lsu_data_i[7:0]
                        : (sz == 2'd1) ? lsu_data_i[8*(i%2) +: 8]
                        : lsu_data_i[8*i +: 8];
  end

  assign ld_b = mem.data_rdata[8*off_q +: 8];
  assign ld_h = off_q[1] ? mem.data_rdata[31:16] : mem.data_rdata[15:0];

  always_comb begin
    ld_ext = mem.data_rdata;
    case (size_q)
      3'd0:    ld_ext = {{24{ld_b[7]}}, ld_b};
      3'd1:    ld_ext = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_ext = {24'd0, ld_b};
      3'd5:    ld_ext = {16'd0, ld_h};
      default: ld_ext = mem.data_rdata;
    endcase
  end

  assign lsu_stall_req_o = lsu_req_i & (state != S_DONE);

  assign mem.data_req   = req_q.req;
  assign mem.data_we    = req_q.we;
  assign mem.data_be    = req_q.be;
  assign mem.data_addr  = {req_q.word, 2'b00};
  assign mem.data_wdata = req_q.wdata;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= S_IDLE;
      req_q      <= '0;
      size_q     <= '0;
      off_q      <= '0;
      lsu_data_o <= '0;
      lsu_err_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (lsu_req_i) begin
          if (illegal) begin
            lsu_err_o <= 1'b1;
            state     <= S_DONE;
          end else begin
            req_q.req   <= 1'b1;
            req_q.we    <= lsu_we_i;
            req_q.be    <= be_nxt;
            req_q.word  <= lsu_addr_i[31:2];
            req_q.wdata <= wdata_nxt;
            // Keep size/offset so extraction does not depend on the core holding inputs.
            size_q      <= lsu_size_i;
            off_q       <= off;
            state       <= S_BUSY;
          end
        end
        S_BUSY: if (mem.data_rvalid) begin
          req_q.req <= 1'b0;
          if (!req_q.we) lsu_data_o <= ld_ext;
          state <= S_DONE;
        end
        S_DONE: begin
          lsu_err_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_riscv.sv
// Bench for lsu_riscv: directed vector table, hand corner sequences, and random
// accesses checked against a byte-arithmetic reference model.
module tb_lsu_riscv;
  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o, lsu_err_o;

  lsu_riscv_if mem();

  lsu_riscv dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o), .lsu_err_o(lsu_err_o),
    .mem(mem)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_ld = '0;

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr, d, rd;
    int          lat;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        eerr;
    logic [31:0] eld;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: access width n bytes; enables are n contiguous bits at the byte
  // offset; store bytes repeat modulo n; loads shift, mask and extend.
  function automatic void model(input logic we, input logic [2:0] size,
      input logic [31:0] addr, d, rd, prev,
      output logic [3:0] be, output logic [31:0] wd, output logic err, output logic [31:0] ld);
    int n;
    logic [31:0] mask, v;
    n   = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    err = (size == 3'd3 || size == 3'd6 || size == 3'd7) || (addr % n != 0);
    be  = 4'(((1 << n) - 1) << addr[1:0]);
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*(k % n) +: 8];
    if (err || we) ld = prev;
    else begin
      mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*n)) - 1);
      v = (rd >> (8*addr[1:0])) & mask;
      if (!size[2] && n < 4 && v[8*n-1]) v = v | ~mask;
      ld = v;
    end
  endfunction

  // One access starting at cycle 0; returns at the negedge of its DONE cycle.
  task automatic run(input vec_t v);
    int w;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_size_i = v.size;
    lsu_addr_i = v.addr; lsu_data_i = v.d; mem.data_rvalid = 1'b0;
    #1;
    chk({v.nm, " c0 stall"}, lsu_stall_req_o, 1'b1);
    chk({v.nm, " c0 err clear"}, lsu_err_o, 1'b0);
    chk({v.nm, " c0 no req"}, mem.data_req, 1'b0);
    @(negedge clk_i);
    if (!v.eerr) begin
      w = 0;
      forever begin
        chk({v.nm, " busy stall"}, lsu_stall_req_o, 1'b1);
        chk({v.nm, " data_req"}, mem.data_req, 1'b1);
        chk({v.nm, " addr"}, mem.data_addr, {v.addr[31:2], 2'b00});
        chk({v.nm, " be"}, mem.data_be, v.ebe);
        chk({v.nm, " we"}, mem.data_we, v.we);
        if (v.we) chk({v.nm, " wdata"}, mem.data_wdata, v.ewd);
        mem.data_rvalid = (w == v.lat);
        mem.data_rdata  = (w == v.lat) ? v.rd : $urandom;
        @(negedge clk_i);
        if (w == v.lat) break;
        w++;
        if (w > 64) begin
          chk({v.nm, " wait bound"}, 32'(w), 32'(v.lat));
          break;
        end
      end
      mem.data_rvalid = 1'b0;
      chk({v.nm, " done stall"}, lsu_stall_req_o, 1'b0);
      chk({v.nm, " done req low"}, mem.data_req, 1'b0);
      chk({v.nm, " done err"}, lsu_err_o, 1'b0);
    end else begin
      chk({v.nm, " err"}, lsu_err_o, 1'b1);
      chk({v.nm, " err stall"}, lsu_stall_req_o, 1'b0);
      chk({v.nm, " err no req"}, mem.data_req, 1'b0);
    end
    chk({v.nm, " ld data"}, lsu_data_o, v.eld);
    exp_ld = v.eld;
    lsu_req_i = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic [2:0] sizes[13] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

  initial begin
    tbl.push_back('{"LB",   0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 4'b1000, 32'h0, 0, 32'hFFFF_FF80});
    tbl.push_back('{"LHU",  0, 3'd5, 32'h202, 32'h0, 32'h8001_1234, 3, 4'b1100, 32'h0, 0, 32'h0000_8001});
    tbl.push_back('{"SB",   1, 3'd0, 32'h301, 32'h1234_56AB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 0, 32'h0000_8001});
    tbl.push_back('{"SH",   1, 3'd1, 32'h302, 32'hDEAD_BEEF, 32'h0, 1, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0000_8001});
    tbl.push_back('{"LWmis",0, 3'd2, 32'h401, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0000_8001});
    tbl.push_back('{"SZ3",  0, 3'd3, 32'h400, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0000_8001});
    tbl.push_back('{"LW",   0, 3'd2, 32'h500, 32'h0, 32'hCAFE_F00D, 1, 4'b1111, 32'h0, 0, 32'hCAFE_F00D});
    tbl.push_back('{"LH",   0, 3'd1, 32'h600, 32'h0, 32'h1234_F00F, 0, 4'b0011, 32'h0, 0, 32'hFFFF_F00F});
    tbl.push_back('{"LBU",  0, 3'd4, 32'h601, 32'h0, 32'h0000_8F00, 2, 4'b0010, 32'h0, 0, 32'h0000_008F});
    tbl.push_back('{"SW",   1, 3'd2, 32'h700, 32'h0102_0304, 32'h0, 2, 4'b1111, 32'h0102_0304, 0, 32'h0000_008F});
    tbl.push_back('{"LHmis",0, 3'd5, 32'h203, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0000_008F});
    tbl.push_back('{"SZ6",  1, 3'd6, 32'h800, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0000_008F});
    tbl.push_back('{"SZ7",  0, 3'd7, 32'h800, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1, 32'h0000_008F});

    arstn_i = 1'b0; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2;
    lsu_addr_i = '0; lsu_data_i = '0; mem.data_rvalid = 1'b0; mem.data_rdata = '0;
    repeat (2) @(negedge clk_i);
    chk("rst stall follows req", lsu_stall_req_o, 1'b1);
    lsu_req_i = 1'b0; #1;
    chk("rst stall low", lsu_stall_req_o, 1'b0);
    chk("rst data_req", mem.data_req, 1'b0);
    chk("rst be", mem.data_be, 4'b0);
    chk("rst addr", mem.data_addr, 32'h0);
    chk("rst lsu_data", lsu_data_o, 32'h0);
    chk("rst err", lsu_err_o, 1'b0);
    @(negedge clk_i); arstn_i = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Stray rvalid while idle must not change anything.
    @(negedge clk_i);
    mem.data_rvalid = 1'b1; mem.data_rdata = 32'h5555_5555;
    @(negedge clk_i);
    mem.data_rvalid = 1'b0;
    chk("stray rvalid req", mem.data_req, 1'b0);
    chk("stray rvalid data", lsu_data_o, exp_ld);
    chk("stray rvalid err", lsu_err_o, 1'b0);

    // Reset asserted mid-BUSY.
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h900;
    @(negedge clk_i);
    chk("pre-rst busy req", mem.data_req, 1'b1);
    #2 arstn_i = 1'b0; #1;
    chk("midrst data_req", mem.data_req, 1'b0);
    chk("midrst be", mem.data_be, 4'b0);
    chk("midrst addr", mem.data_addr, 32'h0);
    chk("midrst we", mem.data_we, 1'b0);
    chk("midrst lsu_data", lsu_data_o, 32'h0);
    chk("midrst stall=req", lsu_stall_req_o, 1'b1);
    exp_ld = '0;
    @(negedge clk_i); lsu_req_i = 1'b0; arstn_i = 1'b1;
    run('{"SWpost", 1, 3'd2, 32'hA00, 32'h7654_3210, 32'h0, 1, 4'b1111, 32'h7654_3210, 0, 32'h0});

    for (int i = 0; i < 60; i++) begin
      rv.nm   = "RND";
      rv.we   = 1'($urandom_range(1));
      rv.size = sizes[$urandom_range(12)];
      rv.addr = $urandom;
      if ($urandom_range(3) != 0) rv.addr[1:0] = (rv.size[1:0] == 2'd0) ? rv.addr[1:0]
                                               : (rv.size[1:0] == 2'd1) ? {rv.addr[1], 1'b0} : 2'b00;
      rv.d    = $urandom;
      rv.rd   = $urandom;
      rv.lat  = $urandom_range(3);
      model(rv.we, rv.size, rv.addr, rv.d, rv.rd, exp_ld, rv.ebe, rv.ewd, rv.eerr, rv.eld);
      run(rv);
    end

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
